// File: rtl/context_parameter_memory.sv
// context_parameter_memory
//   Per-context storage of the JPEG-LS adaptive parameters A, B, C, N and Nn,
//   indexed by context number Q.
//
//   After reset, or on a clear_context pulse, an initialisation sweep loads
//   every context with its start values {A_INIT, 0, 0, N_INIT, 0}. The sweep
//   writes one entry per cycle. While it runs, read and write strobes are
//   ignored.
//
//   Reads have a one-cycle latency. Writes are masked per field:
//     - bit [0] writes A, B, C and N;
//     - bit [1] writes A, N and Nn.
//   When a read and a write hit the same context in the same cycle, the
//   written fields are forwarded to the read data (write-first).
//   Out-of-range contexts behave as follows:
//     - writes are dropped;
//     - reads return valid all-zero data.
//
// Ports
//   clk                  in   rising-edge clock
//   reset                in   asynchronous active-low reset
//   clear_context        in   pulse: restart the initialisation sweep
//   init_busy            out  sweep in progress
//   context_ready        out  memory accepts reads and writes
//   read_Context_Memory  in   read strobe
//   Q_Read               in   read context index
//   write_Context_Memory in   field-group write enables
//   Q_Write              in   write context index
//   A/B/C/N/Nn_Write     in   write data, stored verbatim
//   A/B/C/N/Nn_Read      out  registered read data
//   read_valid           out  read data valid, one cycle after the strobe
module context_parameter_memory #(
  parameter int Q_length     = 9,
  parameter int A_length     = 16,
  parameter int B_length     = 7,
  parameter int C_length     = 8,
  parameter int N_length     = 7,
  parameter int Nn_length    = 7,
  parameter int Context_rw   = 2,
  parameter int NUM_CONTEXTS = 367,
  parameter int A_INIT       = 4,
  parameter int N_INIT       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_context,
  output logic                  init_busy,
  output logic                  context_ready,
  input  logic                  read_Context_Memory,
  input  logic [Q_length-1:0]   Q_Read,
  input  logic [Context_rw-1:0] write_Context_Memory,
  input  logic [Q_length-1:0]   Q_Write,
  input  logic [A_length-1:0]   A_Write,
  input  logic [B_length-1:0]   B_Write,
  input  logic [C_length-1:0]   C_Write,
  input  logic [N_length-1:0]   N_Write,
  input  logic [Nn_length-1:0]  Nn_Write,
  output logic [A_length-1:0]   A_Read,
  output logic [B_length-1:0]   B_Read,
  output logic [C_length-1:0]   C_Read,
  output logic [N_length-1:0]   N_Read,
  output logic [Nn_length-1:0]  Nn_Read,
  output logic                  read_valid
);

  // Word layout, MSB to LSB: {A, B, C, N, Nn}
  localparam int W      = A_length + B_length + C_length + N_length + Nn_length;
  localparam int NN_LSB = 0;
  localparam int N_LSB  = NN_LSB + Nn_length;
  localparam int C_LSB  = N_LSB + N_length;
  localparam int B_LSB  = C_LSB + C_length;
  localparam int A_LSB  = B_LSB + B_length;

  localparam logic [Q_length-1:0] Q_LIMIT = Q_length'(NUM_CONTEXTS);
  localparam logic [Q_length-1:0] Q_LAST  = Q_length'(NUM_CONTEXTS - 1);
  localparam logic [W-1:0] INIT_WORD = {A_length'(A_INIT), {B_length{1'b0}},
                                        {C_length{1'b0}}, N_length'(N_INIT),
                                        {Nn_length{1'b0}}};

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t              state, state_next;
  logic [Q_length-1:0] count, count_next;
  logic                init_wr;

  logic [W-1:0] mem [0:NUM_CONTEXTS-1];

  logic                        wr_ok, rd_ok, rd_en, byp;
  logic                        wr_a, wr_b, wr_c, wr_n, wr_nn;
  logic [W-1:0]                rd_raw_p0;
  logic [A_length-1:0]         a_fwd_p0;
  logic signed [B_length-1:0]  b_fwd_p0;
  logic signed [C_length-1:0]  c_fwd_p0;
  logic [N_length-1:0]         n_fwd_p0;
  logic [Nn_length-1:0]        nn_fwd_p0;

  // ---- control FSM: state register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_INIT;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // ---- control FSM: next state ----
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      S_INIT: begin
        if (clear_context) begin
          count_next = '0;
        end else if (count == Q_LAST) begin
          state_next = S_READY;
          count_next = '0;
        end else begin
          count_next = count + Q_length'(1);
        end
      end
      S_READY: begin
        if (clear_context) begin
          state_next = S_INIT;
          count_next = '0;
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  // ---- control FSM: outputs ----
  always_comb begin
    init_busy     = (state == S_INIT);
    context_ready = (state == S_READY);
    init_wr       = (state == S_INIT);
  end

  // ---- stage p0: field enables, storage read, same-address bypass ----
  always_comb begin
    wr_ok = context_ready && (Q_Write < Q_LIMIT) && (write_Context_Memory != '0);
    rd_ok = Q_Read < Q_LIMIT;
    rd_en = context_ready && read_Context_Memory;
    // A and N belong to both field groups; B and C only to group 0; Nn only to group 1
    wr_a  = wr_ok && (write_Context_Memory[0] || write_Context_Memory[1]);
    wr_b  = wr_ok && write_Context_Memory[0];
    wr_c  = wr_ok && write_Context_Memory[0];
    wr_n  = wr_a;
    wr_nn = wr_ok && write_Context_Memory[1];
    rd_raw_p0 = rd_ok ? mem[Q_Read] : '0;
    // the storage array returns pre-write data, so forward written fields explicitly
    byp = wr_ok && rd_ok && (Q_Write == Q_Read);
    a_fwd_p0  = (byp && wr_a)  ? A_Write  : rd_raw_p0[A_LSB  +: A_length];
    b_fwd_p0  = (byp && wr_b)  ? B_Write  : rd_raw_p0[B_LSB  +: B_length];
    c_fwd_p0  = (byp && wr_c)  ? C_Write  : rd_raw_p0[C_LSB  +: C_length];
    n_fwd_p0  = (byp && wr_n)  ? N_Write  : rd_raw_p0[N_LSB  +: N_length];
    nn_fwd_p0 = (byp && wr_nn) ? Nn_Write : rd_raw_p0[NN_LSB +: Nn_length];
  end

  // Storage: the init sweep owns the write port while it runs
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[count] <= INIT_WORD;
    end else begin
      if (wr_a)  mem[Q_Write][A_LSB  +: A_length]  <= A_Write;
      if (wr_b)  mem[Q_Write][B_LSB  +: B_length]  <= B_Write;
      if (wr_c)  mem[Q_Write][C_LSB  +: C_length]  <= C_Write;
      if (wr_n)  mem[Q_Write][N_LSB  +: N_length]  <= N_Write;
      if (wr_nn) mem[Q_Write][NN_LSB +: Nn_length] <= Nn_Write;
    end
  end

  // ---- stage p1: registered read data ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_valid <= 1'b0;
      A_Read     <= '0;
      B_Read     <= '0;
      C_Read     <= '0;
      N_Read     <= '0;
      Nn_Read    <= '0;
    end else begin
      read_valid <= rd_en;
      if (rd_en) begin
        A_Read  <= a_fwd_p0;
        B_Read  <= b_fwd_p0;
        C_Read  <= c_fwd_p0;
        N_Read  <= n_fwd_p0;
        Nn_Read <= nn_fwd_p0;
      end
    end
  end

endmodule

// File: tb/tb_context_parameter_memory.sv
// tb_context_parameter_memory
//   Directed bench for context_parameter_memory. It covers:
//     - the reset state;
//     - the initialisation sweep and its duration;
//     - masked writes and same-cycle bypass;
//     - out-of-range contexts;
//     - clear_context restarts;
//     - asynchronous reset in the middle of a sweep.
module tb_context_parameter_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_context;
  logic        init_busy, context_ready;
  logic        read_Context_Memory;
  logic [8:0]  Q_Read, Q_Write;
  logic [1:0]  write_Context_Memory;
  logic [15:0] A_Write, A_Read;
  logic [6:0]  B_Write, B_Read;
  logic [7:0]  C_Write, C_Read;
  logic [6:0]  N_Write, N_Read;
  logic [6:0]  Nn_Write, Nn_Read;
  logic        read_valid;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  context_parameter_memory dut (
    .clk                  (clk),
    .reset                (reset),
    .clear_context        (clear_context),
    .init_busy            (init_busy),
    .context_ready        (context_ready),
    .read_Context_Memory  (read_Context_Memory),
    .Q_Read               (Q_Read),
    .write_Context_Memory (write_Context_Memory),
    .Q_Write              (Q_Write),
    .A_Write              (A_Write),
    .B_Write              (B_Write),
    .C_Write              (C_Write),
    .N_Write              (N_Write),
    .Nn_Write             (Nn_Write),
    .A_Read               (A_Read),
    .B_Read               (B_Read),
    .C_Read               (C_Read),
    .N_Read               (N_Read),
    .Nn_Read              (Nn_Read),
    .read_valid           (read_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [15:0] a, input logic [6:0] b,
                        input logic [7:0] c, input logic [6:0] n, input logic [6:0] nn,
                        input logic v);
    chk({tag, "_A"},  32'(A_Read),  32'(a));
    chk({tag, "_B"},  32'(B_Read),  32'(b));
    chk({tag, "_C"},  32'(C_Read),  32'(c));
    chk({tag, "_N"},  32'(N_Read),  32'(n));
    chk({tag, "_Nn"}, 32'(Nn_Read), 32'(nn));
    chk({tag, "_vld"}, 32'(read_valid), 32'(v));
  endtask

  // inputs are driven just after a falling edge; outputs are sampled at the next falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [8:0] q);
    Q_Read = q;
    read_Context_Memory = 1'b1;
    step();
    read_Context_Memory = 1'b0;
  endtask

  task automatic wr(input logic [1:0] bits, input logic [8:0] q, input logic [15:0] a,
                    input logic [6:0] b, input logic [7:0] c, input logic [6:0] n,
                    input logic [6:0] nn);
    write_Context_Memory = bits;
    Q_Write = q;
    A_Write = a; B_Write = b; C_Write = c; N_Write = n; Nn_Write = nn;
    step();
    write_Context_Memory = 2'b00;
  endtask

  task automatic wait_ready(input string tag);
    int cnt = 0;
    while (!context_ready && cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk(tag, 32'(cnt), 32'd367);
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear_context = 1'b1;
    step();
    clear_context = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clear_context = 1'b0;
    read_Context_Memory = 1'b0;
    Q_Read = '0;
    write_Context_Memory = 2'b00;
    Q_Write = '0;
    A_Write = '0; B_Write = '0; C_Write = '0; N_Write = '0; Nn_Write = '0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(init_busy), 32'd1);
    chk("rst_ready", 32'(context_ready), 32'd0);
    chk_rd("rst", 16'd0, 7'd0, 8'd0, 7'd0, 7'd0, 1'b0);

    // 1: initialisation sweep after reset release
    reset = 1'b1;
    wait_ready("init_cycles");
    chk("init_busy_done", 32'(init_busy), 32'd0);
    rd(9'd0);   chk_rd("init_q0",   16'd4, 7'd0, 8'd0, 7'd1, 7'd0, 1'b1);
    rd(9'd200); chk_rd("init_q200", 16'd4, 7'd0, 8'd0, 7'd1, 7'd0, 1'b1);
    rd(9'd366); chk_rd("init_q366", 16'd4, 7'd0, 8'd0, 7'd1, 7'd0, 1'b1);

    // 2: group-0 write leaves Nn untouched
    wr(2'b01, 9'd17, 16'd100, 7'h7D, 8'd5, 7'd9, 7'd7);
    rd(9'd17);  chk_rd("wr0_q17", 16'd100, 7'h7D, 8'd5, 7'd9, 7'd0, 1'b1);
    step();     chk_rd("idle_hold", 16'd100, 7'h7D, 8'd5, 7'd9, 7'd0, 1'b0);

    // 3: group-1 write with same-cycle read (B and C data must be masked)
    write_Context_Memory = 2'b10;
    Q_Write = 9'd365;
    A_Write = 16'd50; B_Write = 7'd11; C_Write = 8'd22; N_Write = 7'd3; Nn_Write = 7'd2;
    rd(9'd365);
    write_Context_Memory = 2'b00;
    chk_rd("byp1_q365", 16'd50, 7'd0, 8'd0, 7'd3, 7'd2, 1'b1);
    rd(9'd365); chk_rd("stored_q365", 16'd50, 7'd0, 8'd0, 7'd3, 7'd2, 1'b1);

    // group-0 bypass: Nn comes from storage
    write_Context_Memory = 2'b01;
    Q_Write = 9'd200;
    A_Write = 16'h0ABC; B_Write = 7'h40; C_Write = 8'h80; N_Write = 7'h11; Nn_Write = 7'h55;
    rd(9'd200);
    write_Context_Memory = 2'b00;
    chk_rd("byp0_q200", 16'h0ABC, 7'h40, 8'h80, 7'h11, 7'd0, 1'b1);

    // both groups with same-cycle read, stored verbatim
    write_Context_Memory = 2'b11;
    Q_Write = 9'd5;
    A_Write = 16'h1234; B_Write = 7'h7F; C_Write = 8'hFF; N_Write = 7'h7F; Nn_Write = 7'h55;
    rd(9'd5);
    write_Context_Memory = 2'b00;
    chk_rd("byp3_q5", 16'h1234, 7'h7F, 8'hFF, 7'h7F, 7'h55, 1'b1);

    // 4: out-of-range context
    wr(2'b11, 9'd400, 16'hBEEF, 7'h2A, 8'h3C, 7'h19, 7'h33);
    rd(9'd400); chk_rd("oor_q400", 16'd0, 7'd0, 8'd0, 7'd0, 7'd0, 1'b1);
    rd(9'd0);   chk_rd("oor_q0",   16'd4, 7'd0, 8'd0, 7'd1, 7'd0, 1'b1);
    rd(9'd366); chk_rd("oor_q366", 16'd4, 7'd0, 8'd0, 7'd1, 7'd0, 1'b1);
    rd(9'd17);  chk_rd("oor_q17",  16'd100, 7'h7D, 8'd5, 7'd9, 7'd0, 1'b1);
    rd(9'd5);   chk_rd("oor_q5",   16'h1234, 7'h7F, 8'hFF, 7'h7F, 7'h55, 1'b1);

    // 5: clear_context, traffic ignored during the sweep, restart after 100 cycles
    pulse_clear();
    chk("clr_busy",  32'(init_busy), 32'd1);
    chk("clr_ready", 32'(context_ready), 32'd0);
    wr(2'b11, 9'd17, 16'h7777, 7'h01, 8'h02, 7'h03, 7'h04);
    rd(9'd17);  chk_rd("sweep_rd", 16'h1234, 7'h7F, 8'hFF, 7'h7F, 7'h55, 1'b0);
    rd(9'd0);   chk_rd("sweep_rd2", 16'h1234, 7'h7F, 8'hFF, 7'h7F, 7'h55, 1'b0);
    repeat (96) step();
    pulse_clear();
    wait_ready("reclear_cycles");
    rd(9'd17);  chk_rd("clr_q17", 16'd4, 7'd0, 8'd0, 7'd1, 7'd0, 1'b1);
    rd(9'd5);   chk_rd("clr_q5",  16'd4, 7'd0, 8'd0, 7'd1, 7'd0, 1'b1);

    // 6: asynchronous reset 50 cycles into a sweep
    pulse_clear();
    repeat (50) step();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy",  32'(init_busy), 32'd1);
    chk("arst_ready", 32'(context_ready), 32'd0);
    chk_rd("arst", 16'd0, 7'd0, 8'd0, 7'd0, 7'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    wait_ready("rst_sweep_cycles");
    rd(9'd366); chk_rd("post_rst_q366", 16'd4, 7'd0, 8'd0, 7'd1, 7'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
